bp_be_fe_queue_rollback: RTL

BP_BE_FE_QUEUE_ROLLBACK -- requirements
Module: bp_be_fe_queue_rollback

---
 rtl/bp_be_fe_queue_rollback_pkg.sv | 39 +++
 rtl/bsg_mem_1r1w.sv | 37 +++
 rtl/bp_be_fe_queue_rollback.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bp_be_fe_queue_rollback_pkg.sv
// Shared FE/BE interface package.
//
// Holds the FE-queue entry layout and its width macro. The queue defaults its
// entry width to the width of this struct. It also holds the read-pointer
// operation type, which the queue uses to resolve clear/roll/yumi priority.
//
// Ports: none (package).

`ifndef BP_FE_QUEUE_WIDTH
`define BP_FE_QUEUE_WIDTH 64
`endif

package bp_be_fe_queue_rollback_pkg;

    // Kind of message the front end pushes toward the back end.
    typedef enum logic [1:0] {
        e_fe_fetch       = 2'd0,
        e_fe_exception   = 2'd1,
        e_fe_icache_miss = 2'd2,
        e_fe_reserved    = 2'd3
    } bp_fe_msg_type_e;

    // One FE-queue entry: the message type plus an opaque payload.
    typedef struct packed {
        bp_fe_msg_type_e                 msg_type;
        logic [`BP_FE_QUEUE_WIDTH-3:0]   payload;
    } bp_fe_queue_s;

    localparam int fe_queue_width_gp = $bits(bp_fe_queue_s);

    // What the read pointer does this cycle, after priority is resolved.
    typedef enum logic [1:0] {
        e_rd_hold    = 2'd0,
        e_rd_advance = 2'd1,
        e_rd_roll    = 2'd2,
        e_rd_clear   = 2'd3
    } rd_op_e;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-file memory with an asynchronous read port.
//
// Ports:
//   clk_i     - write clock
//   w_v_i     - write enable
//   w_addr_i  - write address
//   w_data_i  - write data
//   r_addr_i  - read address
//   r_data_o  - read data (combinational from r_addr_i)
//
// The contents are not reset. A write becomes visible on the read port only
// after the clock edge that performs it, so there is no write-to-read bypass.

module bsg_mem_1r1w #(
    parameter  int width_p   = 64,
    parameter  int els_p     = 8,
    localparam int addr_w_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 w_v_i,
    input  logic [addr_w_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic [addr_w_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_rollback.sv
// FE-to-BE queue with speculative reads and rollback.
//
// The consumer reads entries speculatively with yumi_i. It later either
// retires the oldest read entry with deq_i, or rewinds all uncommitted reads
// with roll_i. Three pointers track this state: write, read and commit. Each
// pointer carries an extra wrap bit so that full and empty can be told apart.
//
// Ports:
//   clk_i      - clock
//   reset_n_i  - synchronous active-low reset
//   data_i     - enqueue data
//   v_i        - enqueue valid (accepted when v_i & ready_o)
//   ready_o    - space available
//   data_o     - entry at the read pointer
//   v_o        - unread entry present at the read pointer
//   yumi_i     - speculative read of data_o
//   deq_i      - retire the oldest read entry
//   roll_i     - rewind the read pointer to the commit pointer
//   clr_i      - discard all entries
//   count_o    - occupancy, from the commit pointer to the write pointer

module bp_be_fe_queue_rollback
    import bp_be_fe_queue_rollback_pkg::*;
#(
    parameter  int width_p  = fe_queue_width_gp,
    parameter  int els_p    = 8,
    localparam int ptr_w_lp = $clog2(els_p) + 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                v_i,
    output logic                ready_o,
    output logic [width_p-1:0]  data_o,
    output logic                v_o,
    input  logic                yumi_i,
    input  logic                deq_i,
    input  logic                roll_i,
    input  logic                clr_i,
    output logic [ptr_w_lp-1:0] count_o
);

    localparam logic [ptr_w_lp-1:0] els_lp = ptr_w_lp'(els_p);
    localparam logic [ptr_w_lp-1:0] one_lp = ptr_w_lp'(1);

    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] cptr_q, cptr_d;
    logic [ptr_w_lp-1:0] occupancy;
    logic                full;
    logic                enq;
    logic                deq;
    rd_op_e              rd_op;

    // The pointers wrap modulo 2*els_p, so the modular difference is the
    // occupancy. The outputs are forced idle while reset is held. This covers
    // the time before the first reset edge has cleared the pointers.
    assign occupancy = wptr_q - cptr_q;
    assign full      = (occupancy == els_lp);
    assign ready_o   = reset_n_i & ~full;
    assign v_o       = reset_n_i & (rptr_q != wptr_q);
    assign count_o   = reset_n_i ? occupancy : '0;

    // clr_i overrides everything. It drops the same-cycle enqueue and deq
    // and moves both trailing pointers up to the write pointer. A roll
    // targets the commit pointer after any same-cycle deq.
    always_comb begin
        enq    = v_i & ready_o & ~clr_i;
        deq    = deq_i & ~clr_i;
        wptr_d = wptr_q + ptr_w_lp'(enq);
        cptr_d = cptr_q + ptr_w_lp'(deq);
        rptr_d = rptr_q;

        if (clr_i) begin
            rd_op = e_rd_clear;
        end else if (roll_i) begin
            rd_op = e_rd_roll;
        end else if (yumi_i) begin
            rd_op = e_rd_advance;
        end else begin
            rd_op = e_rd_hold;
        end

        case (rd_op)
            e_rd_advance: rptr_d = rptr_q + one_lp;
            e_rd_roll:    rptr_d = cptr_d;
            e_rd_clear: begin
                rptr_d = wptr_q;
                cptr_d = wptr_q;
            end
            default:      rptr_d = rptr_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    bsg_mem_1r1w #(
        .width_p (width_p),
        .els_p   (els_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_q[ptr_w_lp-2:0]),
        .w_data_i (data_i),
        .r_addr_i (rptr_q[ptr_w_lp-2:0]),
        .r_data_o (data_o)
    );

`ifndef SYNTHESIS
    // Illegal consumer handshakes, and a write must never land while full.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!yumi_i || v_o);
            assert (!deq_i || (cptr_q != rptr_q));
            assert (!(enq && full));
        end
    end
`endif

endmodule
